// File: rtl/spi_pkg.sv
// Shared SPI definitions for the controller and peripheral.
// Mode 0 link: SCLK idles low, data sampled on the rising edge.
package spi_pkg;

  localparam int SPI_WORD_BITS = 8;
  localparam int SPI_CNT_W     = $clog2(SPI_WORD_BITS);

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchroniser for one asynchronous input.
// Reset value is chosen per instance to match the idle level.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] ff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ff <= {N{RST_VAL}};
    end else begin
      ff <= {ff[N-2:0], i_d};
    end
  end

  assign o_q = ff[N-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode 0 peripheral: oversampled SCLK/CS_N/MOSI,
// byte RX strobe and single-entry TX holding register.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEFAULT_TX  = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_underrun,
  output logic       o_busy
);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_sclk),
    .o_q    (sclk_s)
  );

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_cs_n),
    .o_q    (cs_s)
  );

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_mosi),
    .o_q    (mosi_s)
  );

  // Reset preloads CS_N high in the chain, so a CS_N held low across
  // reset would look like a fresh select; only arm once real high is seen.
  logic [2:0] flush_cnt;
  logic       flushed;
  logic       armed_q;

  assign flushed = (flush_cnt == 3'(SYNC_STAGES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      flush_cnt <= '0;
      armed_q   <= 1'b0;
    end else begin
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
      armed_q <= armed_q | (flushed & cs_s);
      if (!flushed) begin
        flush_cnt <= flush_cnt + 3'd1;
      end
    end
  end

  logic sclk_rise, sclk_fall;
  logic cs_fall, cs_rise;

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = armed_q & cs_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_q;

  spi_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (cs_fall) state_d = ACTIVE;
      ACTIVE: if (cs_rise) state_d = IDLE;
    endcase
  end

  logic [SPI_CNT_W-1:0] bit_cnt;
  logic [6:0]           rx_shift;
  logic [7:0]           tx_q, tx_next;
  logic [7:0]           hold_q;
  logic                 hold_full;
  logic                 start, stop, act;
  logic                 rise_ev, fall_ev;
  logic                 load, shift, wr;

  always_comb begin
    start   = (state_q == IDLE) & cs_fall;
    stop    = (state_q == ACTIVE) & cs_rise;
    act     = (state_q == ACTIVE) & ~cs_rise;
    rise_ev = act & sclk_rise;
    fall_ev = act & sclk_fall;
    load    = start | (fall_ev & (bit_cnt == '0));
    shift   = fall_ev & (bit_cnt != '0);
    wr      = i_tx_valid & ~hold_full;
  end

  always_comb begin
    tx_next = tx_q;
    unique case (1'b1)
      load:    tx_next = hold_full ? hold_q : DEFAULT_TX;
      shift:   tx_next = {tx_q[6:0], 1'b0};
      default: tx_next = tx_q;
    endcase
  end

  logic       miso_q, oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, underrun_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_q       <= '0;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_next;
      miso_q     <= (state_d == ACTIVE) & tx_next[7];
      oe_q       <= (state_d == ACTIVE);
      underrun_q <= load & ~hold_full;
      rx_valid_q <= rise_ev & (bit_cnt == SPI_CNT_W'(7));
      hold_full  <= wr | (hold_full & ~load);
      if (wr) begin
        hold_q <= i_tx_data;
      end
      if (start | stop) begin
        bit_cnt <= '0;
      end else if (rise_ev) begin
        bit_cnt <= bit_cnt + SPI_CNT_W'(1);
      end
      if (rise_ev) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
      end
      if (rise_ev && bit_cnt == SPI_CNT_W'(7)) begin
        rx_data_q <= {rx_shift, mosi_s};
      end
    end
  end

  assign o_miso        = miso_q;
  assign o_miso_oe     = oe_q;
  assign o_tx_ready    = ~hold_full;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_tx_underrun = underrun_q;
  assign o_busy        = (state_q == ACTIVE);

endmodule
